tick_divider: RTL and testbench
===============================

TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 28, meaning the bit width of the period register and phase counter.
REQ-002 The module SHALL have parameter DEF_DIV, default 100000, meaning the reset period in clk_in cycles (1 kHz at 100 MHz).
REQ-003 The module SHALL have parameter CNT_W, default 16, meaning the bit width of the tick counter.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port clk_in, input, width 1: the system clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-007 The module SHALL have port en, input, width 1: count enable; low freezes the phase counter.
REQ-008 The module SHALL have port load, input, width 1: a one-cycle strobe that loads div_in as the new period.
REQ-009 The module SHALL have port div_in, input, width WIDTH: the requested period in clk_in cycles.
REQ-010 The module SHALL have port tick_out, output, width 1: a one-cycle pulse once per period.
REQ-011 The module SHALL have port sq_out, output, width 1: a square wave that toggles on every tick (period 2P).
REQ-012 The module SHALL have port tick_cnt, output, width CNT_W: the number of ticks since reset, wrapping.
REQ-013 The module SHALL have port period, output, width WIDTH: readback of the active period P.

Function
REQ-014 The block SHALL hold the active period P in a register; the phase counter SHALL run 0..P-1.
REQ-015 On a rising edge with en=1 and load=0, if phase==P-1 then phase<=0 and tick_out<=1; otherwise phase<=phase+1 and tick_out<=0.
REQ-016 tick_out SHALL be registered, high for exactly one clk_in cycle, with tick spacing exactly P cycles (no off-by-one).
REQ-017 With en=0 and load=0, phase SHALL hold its value, and tick_out<=0, sq_out and tick_cnt SHALL hold.
REQ-018 On every edge that sets tick_out<=1, sq_out SHALL toggle and tick_cnt SHALL increment modulo 2^CNT_W (2^CNT_W-1 wraps to 0).
REQ-019 On load=1 the block SHALL set P<=max(div_in,2), phase<=0 and tick_out<=0, with sq_out and tick_cnt held.
REQ-020 div_in values of 0 or 1 SHALL clamp to 2; DEF_DIV<2 SHALL likewise be treated as 2.
REQ-021 load SHALL take priority over en: no tick on a load edge even if phase==P-1.
REQ-022 After load, the first tick SHALL occur on the P-th enabled edge following the load edge.
REQ-023 Timing SHALL be unaffected by div_in while load=0.
REQ-024 period SHALL equal the active P (after clamp) at all times.
REQ-025 The design SHALL be fully synchronous, with no derived clocks; tick_out is intended as a clock enable for downstream logic.

Reset
REQ-026 reset=1 SHALL have priority over load and en.
REQ-027 On reset the block SHALL set P<=DEF_DIV (clamped), phase<=0, tick_out<=0, sq_out<=0 and tick_cnt<=0.
REQ-028 Reset asserted mid-period SHALL discard the partial count; after release with en=1, the first tick SHALL occur on the DEF_DIV-th edge.
REQ-029 All outputs SHALL be valid, with reset values, on the cycle after the reset edge.

Verification
REQ-030 The bench SHALL cover basic period with DEF_DIV=4: reset, then en=1 held -> tick_out high on edges 4, 8, 12; tick_cnt=1,2,3; sq_out=1,0,1.
REQ-031 The bench SHALL cover enable gating with DEF_DIV=4: en=1 for 2 edges, en=0 for 5 edges, en=1 -> first tick on the 2nd edge after en re-asserts; tick_out=0 throughout the gap.
REQ-032 The bench SHALL cover load and clamp: load with div_in=1 -> period=2 and ticks every 2 edges; load with div_in=7 -> period=7 and the first tick 7 edges after load.
REQ-033 The bench SHALL cover a load/tick collision: load asserted on the edge where phase==P-1 -> tick_out=0, tick_cnt unchanged, phase=0.
REQ-034 The bench SHALL cover wrap with CNT_W=2 and DEF_DIV=2: 5 ticks -> tick_cnt sequence 1,2,3,0,1.
REQ-035 The bench SHALL cover reset mid-operation: reset asserted at phase=2 of P=4 together with load=1 -> P=DEF_DIV, all outputs 0; next tick DEF_DIV edges after release.

Source files
------------

// File: rtl/tick_divider.sv
// Programmable tick generator. It emits a one-cycle tick_out pulse every P clk_in cycles.
// It also produces a square wave that toggles on each tick, and a wrapping count of the
// ticks seen since reset. The period P can be reloaded at run time through load/div_in.
// Every output is registered, and the whole block runs on clk_in alone.
module tick_divider #(
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned DEF_DIV = 100000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick_out,
    output logic             sq_out,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [WIDTH-1:0] period
);

    // A period shorter than 2 cannot give a distinct one-cycle pulse, so 2 is the floor.
    localparam logic [WIDTH-1:0] MinPeriod = WIDTH'(2);
    localparam logic [WIDTH-1:0] DefPeriod = (DEF_DIV < 2) ? MinPeriod : WIDTH'(DEF_DIV);

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] load_period;
    logic             at_end;

    assign load_period = (div_in < MinPeriod) ? MinPeriod : div_in;
    assign at_end      = (phase_q == (period_q - WIDTH'(1)));

    // Next state: load beats en, and a disabled cycle freezes the phase but still clears tick.
    always_comb begin
        period_d = period_q;
        phase_d  = phase_q;
        tick_d   = 1'b0;
        sq_d     = sq_q;
        cnt_d    = cnt_q;
        if (load) begin
            period_d = load_period;
            phase_d  = '0;
        end else if (en) begin
            if (at_end) begin
                phase_d = '0;
                tick_d  = 1'b1;
                sq_d    = ~sq_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                phase_d = phase_q + WIDTH'(1);
            end
        end
    end

    // State register with synchronous reset, which takes priority over everything else.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            period_q <= DefPeriod;
            phase_q  <= '0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            phase_q  <= phase_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tick_out = tick_q;
    assign sq_out   = sq_q;
    assign tick_cnt = cnt_q;
    assign period   = period_q;

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider. The table-driven part exercises a DEF_DIV=4 instance.
// Hand-written sequences cover tick-counter wrap (CNT_W=2) and the DEF_DIV<2 reset clamp.
module tb_tick_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEF_DIV=4, 16-bit tick counter.
    logic        rst_a, en_a, ld_a;
    logic [7:0]  div_a;
    logic        tick_a, sq_a;
    logic [15:0] cnt_a;
    logic [7:0]  per_a;

    tick_divider #(.WIDTH(8), .DEF_DIV(4), .CNT_W(16)) dut_a (
        .clk_in(clk), .reset(rst_a), .en(en_a), .load(ld_a), .div_in(div_a),
        .tick_out(tick_a), .sq_out(sq_a), .tick_cnt(cnt_a), .period(per_a)
    );

    // Instance B: DEF_DIV=2, 2-bit tick counter for wrap.
    // Instance C: DEF_DIV=1, which must clamp to 2.
    logic        rst_b, en_b;
    logic        tick_b, sq_b, tick_c, sq_c;
    logic [1:0]  cnt_b;
    logic [15:0] cnt_c;
    logic [7:0]  per_b, per_c;

    tick_divider #(.WIDTH(8), .DEF_DIV(2), .CNT_W(2)) dut_b (
        .clk_in(clk), .reset(rst_b), .en(en_b), .load(1'b0), .div_in(8'd0),
        .tick_out(tick_b), .sq_out(sq_b), .tick_cnt(cnt_b), .period(per_b)
    );

    tick_divider #(.WIDTH(8), .DEF_DIV(1), .CNT_W(16)) dut_c (
        .clk_in(clk), .reset(rst_b), .en(en_b), .load(1'b0), .div_in(8'd0),
        .tick_out(tick_c), .sq_out(sq_c), .tick_cnt(cnt_c), .period(per_c)
    );

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        ld;
        logic [7:0]  div;
        logic        tick;
        logic        sq;
        logic [15:0] cnt;
        logic [7:0]  per;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic e, input logic l, input logic [7:0] d,
                       input logic t, input logic s, input logic [15:0] c,
                       input logic [7:0] p);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.div = d;
        v.tick = t; v.sq = s; v.cnt = c; v.per = p;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_cnt_b [5];
        logic       exp_sq_b [5];
        int         n;

        exp_cnt_b[0] = 2'd1; exp_cnt_b[1] = 2'd2; exp_cnt_b[2] = 2'd3;
        exp_cnt_b[3] = 2'd0; exp_cnt_b[4] = 2'd1;
        exp_sq_b[0] = 1'b1; exp_sq_b[1] = 1'b0; exp_sq_b[2] = 1'b1;
        exp_sq_b[3] = 1'b0; exp_sq_b[4] = 1'b1;

        // Vector fields: rst en ld div_in | expected tick sq cnt period, after that edge.
        add(1, 0, 0, 0, 0, 0, 0, 4);
        // Basic period P=4: ticks on edges 4, 8, 12.
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 1, 1, 1, 4);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 1, 4);
        add(0, 1, 0, 0, 1, 0, 2, 4);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 2, 4);
        add(0, 1, 0, 0, 1, 1, 3, 4);
        // Enable gating: 2 on, 5 off, then tick on the 2nd re-enabled edge.
        add(1, 1, 0, 0, 0, 0, 0, 4);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 0, 0, 4);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 1, 1, 1, 4);
        // Load div_in=1 clamps to 2.
        add(0, 1, 1, 1, 0, 1, 1, 2);
        add(0, 1, 0, 1, 0, 1, 1, 2);
        add(0, 1, 0, 1, 1, 0, 2, 2);
        add(0, 1, 0, 1, 0, 0, 2, 2);
        add(0, 1, 0, 1, 1, 1, 3, 2);
        // Load 7. div_in changes while load=0 must not matter.
        add(0, 1, 1, 7, 0, 1, 3, 7);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 3, 0, 1, 3, 7);
        add(0, 1, 0, 3, 1, 0, 4, 7);
        // Walk to phase 6 (P-1), then load collides with the would-be tick.
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, 0, 4, 7);
        add(0, 1, 1, 5, 0, 0, 4, 5);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 5, 0, 0, 4, 5);
        add(0, 1, 0, 5, 1, 1, 5, 5);
        // Load div_in=0 clamps to 2.
        add(0, 1, 1, 0, 0, 1, 5, 2);
        add(0, 1, 0, 0, 0, 1, 5, 2);
        add(0, 1, 0, 0, 1, 0, 6, 2);
        // P=4, advance to phase 2, then reset together with load=9: reset wins.
        add(0, 1, 1, 4, 0, 0, 6, 4);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 4, 0, 0, 6, 4);
        add(1, 1, 1, 9, 0, 0, 0, 4);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 9, 0, 0, 0, 4);
        add(0, 1, 0, 9, 1, 1, 1, 4);

        rst_a = 1'b1; en_a = 1'b0; ld_a = 1'b0; div_a = '0;
        rst_b = 1'b1; en_b = 1'b0;

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst; en_a = vecs[i].en; ld_a = vecs[i].ld; div_a = vecs[i].div;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d tick", i), 32'(tick_a), 32'(vecs[i].tick));
            check($sformatf("vec%0d sq", i), 32'(sq_a), 32'(vecs[i].sq));
            check($sformatf("vec%0d cnt", i), 32'(cnt_a), 32'(vecs[i].cnt));
            check($sformatf("vec%0d period", i), 32'(per_a), 32'(vecs[i].per));
        end

        // Counter wrap on B, and the DEF_DIV=1 clamp on C.
        rst_b = 1'b1; en_b = 1'b1;
        @(posedge clk);
        #1;
        check("b reset cnt", 32'(cnt_b), 32'd0);
        check("b reset period", 32'(per_b), 32'd2);
        check("c reset period", 32'(per_c), 32'd2);
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!tick_b && n < 6);
            if (!tick_b) check($sformatf("b tick%0d timeout", k), 32'(tick_b), 32'd1);
            check($sformatf("b tick%0d spacing", k), 32'(n), 32'd2);
            check($sformatf("b tick%0d cnt", k), 32'(cnt_b), 32'(exp_cnt_b[k]));
            check($sformatf("b tick%0d sq", k), 32'(sq_b), 32'(exp_sq_b[k]));
            check($sformatf("c tick%0d", k), 32'(tick_c), 32'd1);
        end
        @(posedge clk);
        #1;
        check("b tick width", 32'(tick_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
